// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seven_seg_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SHOW, ARB_GAP} arb_state_t;

  localparam logic [7:0] IDLE_VALUE_DEF = 8'h00;

  // OR-reduces bit positions; exact for one-hot input, 0 for all-zero input.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping around.
module seven_seg_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] c;

  // Walk from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % N_REQ);
      if (req[c]) begin
        valid = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/seven_seg_arbiter.sv
// Round-robin owner of the two-digit display with minimum dwell time.
// Define SEVEN_SEG_ARB_BLANK_EN to insert a blank GAP between owners.
module seven_seg_arbiter
  import seven_seg_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter int         DWELL_CYCLES = 12000000,
  parameter int         GAP_CYCLES   = 1200000,
  parameter logic [7:0] IDLE_VALUE   = IDLE_VALUE_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         disp_din,
  output logic               disp_on,
  output logic               switch_pulse
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  arb_state_t              state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           ptr;
  logic [N_REQ-1:0][7:0]   data_a;
  logic [IW-1:0]           owner;
  logic                    pk_valid;
  logic [IW-1:0]           pk_idx;
  logic                    leave, take, go_gap, go_idle;

  assign data_a = data;
  assign owner  = IW'(onehot_to_idx(8'(grant)));

  // ptr always equals the current/last owner, so one picker covers every case:
  // the old owner is searched last and only wins when nobody else requests.
  seven_seg_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pk_valid),
    .idx   (pk_idx)
  );

  always_comb begin
    take    = 1'b0;
    go_gap  = 1'b0;
    go_idle = 1'b0;
    leave   = !req[owner] || (cnt == '0 && |(req & ~grant));
    case (state)
      ARB_IDLE: take = pk_valid;
      ARB_SHOW:
        if (leave) begin
`ifdef SEVEN_SEG_ARB_BLANK_EN
          go_gap  = pk_valid;
`else
          take    = pk_valid;
`endif
          go_idle = !pk_valid;
        end
      ARB_GAP:
        if (cnt == '0) begin
          take    = pk_valid;
          go_idle = !pk_valid;
        end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ARB_IDLE;
      cnt          <= '0;
      ptr          <= IW'(N_REQ - 1);
      grant        <= '0;
      disp_din     <= IDLE_VALUE;
      disp_on      <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      if (take) begin
        state        <= ARB_SHOW;
        cnt          <= CW'(DWELL_CYCLES - 1);
        ptr          <= pk_idx;
        grant        <= N_REQ'(1) << pk_idx;
        disp_din     <= data_a[pk_idx];
        disp_on      <= 1'b1;
        switch_pulse <= 1'b1;
      end else if (go_gap || go_idle) begin
        state    <= go_gap ? ARB_GAP : ARB_IDLE;
        cnt      <= go_gap ? CW'(GAP_CYCLES - 1) : '0;
        grant    <= '0;
        disp_din <= IDLE_VALUE;
        disp_on  <= 1'b0;
      end else begin
        if (state == ARB_SHOW) disp_din <= data_a[owner];
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
